parameter_register_bank: RTL and testbench

//  Parametrised AXI4-Lite slave holding NUM_PARAMS 32-bit tuning registers for the traffic-light

---
 rtl/parameter_register_pkg.sv | 20 ++
 rtl/parameter_register_axil_if.sv | 123 ++++++++++++
 rtl/parameter_register_bank.sv | 149 ++++++++++++++
 tb/tb_parameter_register_bank.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parameter_register_pkg.sv
// rtl/parameter_register_pkg.sv - register map, response codes and field positions for the parameter bank
package parameter_register_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  localparam int CTRL_OFFSET   = 0;
  localparam int STATUS_OFFSET = 4;
  localparam int PARAM_BASE    = 8;

  localparam int CTRL_COMMIT_BIT    = 0;
  localparam int CTRL_IMMEDIATE_BIT = 1;

  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_COUNT_LSB   = 8;
  localparam int STATUS_NPARAM_LSB  = 16;

endpackage

// File: rtl/parameter_register_axil_if.sv
// rtl/parameter_register_axil_if.sv - AXI4-Lite write/read handshake FSMs feeding a simple register port
module parameter_register_axil_if
  import parameter_register_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [3:0]            wr_strb,
  input  logic                  wr_err,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [31:0]           rd_data,
  input  logic                  rd_err
);

  localparam logic [2:0] W_IDLE    = 3'd0;
  localparam logic [2:0] W_HAVE_AW = 3'd1;
  localparam logic [2:0] W_HAVE_W  = 3'd2;
  localparam logic [2:0] W_EXEC    = 3'd3;
  localparam logic [2:0] W_RESP    = 3'd4;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_RESP = 1'b1;

  logic [2:0] w_state, w_state_nxt;
  logic       r_state, r_state_nxt;
  logic       aw_hs, w_hs, ar_hs;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign wr_en  = (w_state == W_EXEC);
  assign bvalid = (w_state == W_RESP);
  assign rvalid = (r_state == R_RESP);
  assign rd_en  = ar_hs;
  assign rd_addr = araddr;

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_nxt = W_EXEC;
        else if (aw_hs)    w_state_nxt = W_HAVE_AW;
        else if (w_hs)     w_state_nxt = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)   w_state_nxt = W_EXEC;
      W_HAVE_W:  if (aw_hs)  w_state_nxt = W_EXEC;
      W_EXEC:                w_state_nxt = W_RESP;
      W_RESP:    if (bready) w_state_nxt = W_IDLE;
      default:               w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    if (r_state == R_IDLE) begin
      if (ar_hs) r_state_nxt = R_RESP;
    end else if (rready) begin
      r_state_nxt = R_IDLE;
    end
  end

  // READY flags are registered from the next state so they are low throughout reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bresp   <= RESP_OKAY;
      wr_addr <= '0;
      wr_data <= '0;
      wr_strb <= '0;
    end else begin
      w_state <= w_state_nxt;
      awready <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_HAVE_W);
      wready  <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_HAVE_AW);
      if (aw_hs) wr_addr <= awaddr;
      if (w_hs) begin
        wr_data <= wdata;
        wr_strb <= wstrb;
      end
      if (w_state == W_EXEC) bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_state_nxt;
      arready <= (r_state_nxt == R_IDLE);
      if (ar_hs) begin
        rdata <= rd_err ? 32'd0 : rd_data;
        rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: rtl/parameter_register_bank.sv
// rtl/parameter_register_bank.sv - shadow/active tuning registers with frame-synchronous atomic commit
module parameter_register_bank
  import parameter_register_pkg::*;
#(
  parameter int                      NUM_PARAMS   = 8,
  parameter int                      ADDR_WIDTH   = 9,
  parameter logic [NUM_PARAMS*32-1:0] RESET_VALUES = '0,
  parameter bit                      IMMEDIATE_EN = 1'b1
) (
  input  logic                     s00_axi_aclk,
  input  logic                     s00_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]    s00_axi_awaddr,
  input  logic [2:0]               s00_axi_awprot,
  input  logic                     s00_axi_awvalid,
  output logic                     s00_axi_awready,
  input  logic [31:0]              s00_axi_wdata,
  input  logic [3:0]               s00_axi_wstrb,
  input  logic                     s00_axi_wvalid,
  output logic                     s00_axi_wready,
  output logic [1:0]               s00_axi_bresp,
  output logic                     s00_axi_bvalid,
  input  logic                     s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]    s00_axi_araddr,
  input  logic [2:0]               s00_axi_arprot,
  input  logic                     s00_axi_arvalid,
  output logic                     s00_axi_arready,
  output logic [31:0]              s00_axi_rdata,
  output logic [1:0]               s00_axi_rresp,
  output logic                     s00_axi_rvalid,
  input  logic                     s00_axi_rready,
  input  logic                     frame_start,
  output logic [NUM_PARAMS*32-1:0] param_active,
  output logic                     param_update
);

  localparam int CTRL_WORD   = CTRL_OFFSET / 4;
  localparam int STATUS_WORD = STATUS_OFFSET / 4;
  localparam int PARAM_WORD  = PARAM_BASE / 4;

  logic                  wr_en, wr_err, rd_en, rd_err;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [31:0]           wr_data, rd_data;
  logic [3:0]            wr_strb;
  logic [ADDR_WIDTH-3:0] wr_word, rd_word;
  logic                  wr_is_ctrl, wr_is_param, rd_is_param;
  logic                  ctrl_wr, commit_wr, imm_req, apply;
  logic                  pending, imm_pend;
  logic [7:0]            commit_count;
  logic [31:0]           shadow [NUM_PARAMS];
  logic                  unused_sigs;

  parameter_register_axil_if #(.ADDR_WIDTH(ADDR_WIDTH)) u_axil_if (
    .clk     (s00_axi_aclk),
    .rst_n   (s00_axi_aresetn),
    .awaddr  (s00_axi_awaddr),
    .awvalid (s00_axi_awvalid),
    .awready (s00_axi_awready),
    .wdata   (s00_axi_wdata),
    .wstrb   (s00_axi_wstrb),
    .wvalid  (s00_axi_wvalid),
    .wready  (s00_axi_wready),
    .bresp   (s00_axi_bresp),
    .bvalid  (s00_axi_bvalid),
    .bready  (s00_axi_bready),
    .araddr  (s00_axi_araddr),
    .arvalid (s00_axi_arvalid),
    .arready (s00_axi_arready),
    .rdata   (s00_axi_rdata),
    .rresp   (s00_axi_rresp),
    .rvalid  (s00_axi_rvalid),
    .rready  (s00_axi_rready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_err  (wr_err),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_err  (rd_err)
  );

  assign unused_sigs = ^{s00_axi_awprot, s00_axi_arprot, rd_en, wr_addr[1:0], rd_addr[1:0]};

  assign wr_word     = wr_addr[ADDR_WIDTH-1:2];
  assign rd_word     = rd_addr[ADDR_WIDTH-1:2];
  assign wr_is_ctrl  = (int'(wr_word) == CTRL_WORD);
  assign wr_is_param = (int'(wr_word) >= PARAM_WORD) && (int'(wr_word) < PARAM_WORD + NUM_PARAMS);
  assign rd_is_param = (int'(rd_word) >= PARAM_WORD) && (int'(rd_word) < PARAM_WORD + NUM_PARAMS);
  assign wr_err      = !(wr_is_ctrl || wr_is_param);

  assign ctrl_wr   = wr_en && wr_is_ctrl && wr_strb[0];
  assign commit_wr = ctrl_wr && wr_data[CTRL_COMMIT_BIT];
  assign imm_req   = IMMEDIATE_EN && ctrl_wr && wr_data[CTRL_IMMEDIATE_BIT];
  assign apply     = (frame_start && pending) || imm_pend;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int k = 0; k < NUM_PARAMS; k++) shadow[k] <= RESET_VALUES[32*k +: 32];
    end else if (wr_en && wr_is_param) begin
      for (int k = 0; k < NUM_PARAMS; k++) begin
        if (int'(wr_word) == PARAM_WORD + k) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) shadow[k][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // A commit write in the same cycle as a frame commit re-arms pending for the next frame
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      pending      <= 1'b0;
      imm_pend     <= 1'b0;
      commit_count <= 8'd0;
      param_update <= 1'b0;
      param_active <= RESET_VALUES;
    end else begin
      imm_pend     <= imm_req;
      param_update <= apply;
      if (apply) begin
        commit_count <= commit_count + 8'd1;
        for (int k = 0; k < NUM_PARAMS; k++) param_active[32*k +: 32] <= shadow[k];
      end
      if (commit_wr)  pending <= 1'b1;
      else if (apply) pending <= 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (int'(rd_word) == CTRL_WORD) begin
      rd_data[CTRL_COMMIT_BIT] = pending;
    end else if (int'(rd_word) == STATUS_WORD) begin
      rd_data[STATUS_PENDING_BIT]        = pending;
      rd_data[STATUS_COUNT_LSB +: 8]     = commit_count;
      rd_data[STATUS_NPARAM_LSB +: 16]   = 16'(NUM_PARAMS);
    end else if (rd_is_param) begin
      for (int k = 0; k < NUM_PARAMS; k++) begin
        if (int'(rd_word) == PARAM_WORD + k) rd_data = shadow[k];
      end
    end else begin
      rd_err = 1'b1;
    end
  end

endmodule

// File: tb/tb_parameter_register_bank.sv
// tb/tb_parameter_register_bank.sv - randomized scoreboard bench for parameter_register_bank
module tb_parameter_register_bank;

  localparam int NP = 8;
  localparam logic [NP*32-1:0] RV = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
                                     32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_00A5};

  logic            clk, rst_n;
  logic [8:0]      awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [31:0]     wdata, rdata;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;
  logic            frame_start, param_update;
  logic [NP*32-1:0] param_active;

  int tests = 0;
  int fails = 0;
  int upd_seen = 0;
  int exp_updates = 0;

  logic [31:0] m_shadow [NP];
  logic [31:0] m_active [NP];
  logic        m_pending;
  int          m_count;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [NP*32-1:0] rv_v;

  parameter_register_bank #(
    .NUM_PARAMS(NP), .ADDR_WIDTH(9), .RESET_VALUES(RV), .IMMEDIATE_EN(1'b1)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .frame_start(frame_start), .param_active(param_active), .param_update(param_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit in_map_param(input logic [8:0] a);
    int w;
    w = int'(a >> 2);
    return (w >= 2) && (w < 2 + NP);
  endfunction

  function automatic logic [1:0] exp_wresp(input logic [8:0] a);
    return ((a >> 2) == 0 || in_map_param(a)) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [33:0] exp_read(input logic [8:0] a);
    int w;
    w = int'(a >> 2);
    if (w == 0) return {2'b00, 31'd0, m_pending};
    if (w == 1) return {2'b00, 16'(NP), 8'(m_count), 7'd0, m_pending};
    if (in_map_param(a)) return {2'b00, m_shadow[w-2]};
    return {2'b10, 32'd0};
  endfunction

  function automatic logic [NP*32-1:0] model_flat();
    logic [NP*32-1:0] f;
    for (int k = 0; k < NP; k++) f[32*k +: 32] = m_active[k];
    return f;
  endfunction

  task automatic model_init();
    rv_v = RV;
    for (int k = 0; k < NP; k++) begin
      m_shadow[k] = rv_v[32*k +: 32];
      m_active[k] = rv_v[32*k +: 32];
    end
    m_pending = 1'b0;
    m_count = 0;
  endtask

  task automatic model_apply();
    for (int k = 0; k < NP; k++) m_active[k] = m_shadow[k];
    m_pending = 1'b0;
    m_count = (m_count + 1) % 256;
    exp_updates++;
  endtask

  task automatic model_frame();
    if (m_pending) model_apply();
  endtask

  task automatic model_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    w = int'(a >> 2);
    if (w == 0 && s[0]) begin
      if (d[0]) m_pending = 1'b1;
      if (d[1]) model_apply();
    end else if (in_map_param(a)) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_shadow[w-2][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // ---------------- drivers ----------------
  function automatic logic sig_of(input int which);
    case (which)
      0: return awready;
      1: return wready;
      2: return bvalid;
      3: return arready;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sig_of(which)) break;
      n++;
      if (n > 64) begin
        tests++;
        fails++;
        $display("FAIL timeout_%s: got no handshake expected one within 64 cycles", name);
        break;
      end
    end
  endtask

  task automatic axi_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_hold);
    bq.push_back(exp_wresp(a));
    fork
      begin
        repeat (aw_dly) @(posedge clk);
        @(posedge clk); #1;
        awaddr = a; awvalid = 1'b1;
        wait_sig(0, "awready");
        @(posedge clk); #1;
        awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(posedge clk);
        @(posedge clk); #1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        wait_sig(1, "wready");
        @(posedge clk); #1;
        wvalid = 1'b0;
      end
    join
    wait_sig(2, "bvalid");
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      check("bvalid_held", bvalid, 1);
      check("awready_blocked", awready, 0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    wait_sig(2, "bvalid");
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int aw_dly, input int w_dly, input int b_hold);
    axi_write(a, d, s, aw_dly, w_dly, b_hold);
    model_write(a, d, s);
  endtask

  task automatic axi_read(input logic [8:0] a, input int r_dly);
    rq.push_back(exp_read(a));
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    wait_sig(3, "arready");
    @(posedge clk); #1;
    arvalid = 1'b0;
    repeat (r_dly) begin
      @(posedge clk); #1;
    end
    rready = 1'b1;
    wait_sig(4, "rvalid");
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic pulse_frame();
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0; frame_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_init();
    check("reset_handshake", {awready, wready, arready, bvalid, rvalid, param_update}, 0);
    check("reset_resp", {bresp, rresp, rdata}, 0);
    check("reset_active", param_active, model_flat());
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          tests++; fails++;
          $display("FAIL bresp: got unexpected response %0d expected none", bresp);
        end else check("bresp", bresp, bq.pop_front());
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL rdata: got unexpected response %0h expected none", rdata);
        end else check("rresp_rdata", {rresp, rdata}, rq.pop_front());
      end
      if (param_update) upd_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    logic [8:0] a;
    logic [31:0] d;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    do_reset();

    axi_read(9'h008, 0);
    axi_read(9'h004, 1);

    for (int k = 0; k < 4; k++) wr(9'(8 + 4*k), 32'(k + 1), 4'hF, 0, 0, 0);
    wr(9'h000, 32'h1, 4'hF, 0, 0, 0);
    check("active_before_frame", param_active, model_flat());
    axi_read(9'h004, 0);
    model_frame();
    pulse_frame();
    check("active_after_frame", param_active, model_flat());
    check("active_low4", param_active[127:0], {32'd4, 32'd3, 32'd2, 32'd1});
    axi_read(9'h004, 0);

    wr(9'h00C, 32'h0, 4'hF, 0, 0, 0);
    wr(9'h00C, 32'hFFFF_FFFF, 4'b0010, 10, 0, 5);
    axi_read(9'h00D, 2);

    wr(9'h004, 32'h14, 4'hF, 0, 0, 0);
    axi_read(9'h004, 0);
    axi_read(9'h100, 0);

    wr(9'h000, 32'h1, 4'h1, 0, 0, 0);
    model_frame();
    fork
      axi_write(9'h010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(awvalid && awready && wvalid && wready) && n < 64);
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
      end
    join
    model_write(9'h010, 32'hDEAD_BEEF, 4'hF);
    check("coincident_active", param_active, model_flat());
    axi_read(9'h010, 0);

    wr(9'h01C, 32'hCAFE_0123, 4'hF, 0, 1, 0);
    wr(9'h000, 32'h2, 4'hF, 0, 0, 0);
    check("immediate_active", param_active, model_flat());
    axi_read(9'h004, 0);

    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 9);
      a = 9'(($urandom_range(0, 11) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = 9'h100 | 9'($urandom_range(0, 255));
      d = ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'($urandom_range(0, 3));
      if (op < 5) wr(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else if (op < 8) axi_read(a, $urandom_range(0, 3));
      else begin
        model_frame();
        pulse_frame();
      end
      check("random_active", param_active, model_flat());
    end

    do_reset();
    for (int i = 0; i < 256; i++) wr(9'h000, 32'h2, 4'hF, 0, 0, 0);
    check("wrap_active", param_active, model_flat());
    axi_read(9'h004, 0);

    repeat (4) @(posedge clk);
    #1;
    check("update_pulses", upd_seen, exp_updates);
    check("queues_empty", bq.size() + rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
